// File: rtl/stack_ctrl.sv
// Stack push/pop controller: sequences stack-memory transfers and the ESP register write-back
// for PUSH, POP and LOAD_ESP commands, with sticky overflow/underflow fault flags.
module stack_ctrl #(
    parameter logic [31:0] STACK_TOP   = 32'h000fffff,
    parameter logic [31:0] STACK_LIMIT = 32'h000f0000
) (
    input  logic        clock_5,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_data,
    output logic        cmd_ready,
    input  logic [31:0] esp_in,
    output logic [3:0]  esp_rw,
    output logic [31:0] esp_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        pop_valid,
    output logic [31:0] pop_data,
    output logic        overflow,
    output logic        underflow,
    input  logic        flag_clr
);

    typedef enum logic [1:0] {IDLE, PUSH_MEM, POP_MEM, ESP_WR} state_t;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [3:0] ESP_WRITE = 4'h2;
    localparam logic [3:0] ESP_HOLD  = 4'h0;

    // A push that would wrap below zero or land under the limit is refused.
    function automatic logic push_out_of_range(input logic [31:0] esp);
        logic [31:0] next_esp;
        next_esp = esp - 32'd4;
        return (esp < 32'd4) || (next_esp < STACK_LIMIT);
    endfunction

    function automatic logic pop_out_of_range(input logic [31:0] esp);
        return esp >= STACK_TOP;
    endfunction

    state_t      state;
    logic        accept;
    logic [31:0] push_addr;

    always_comb begin
        accept    = cmd_valid && cmd_ready;
        push_addr = esp_in - 32'd4;
    end

    always_ff @(posedge clock_5 or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            esp_rw    <= ESP_HOLD;
            esp_wdata <= 32'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            pop_valid <= 1'b0;
            pop_data  <= 32'd0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            // Clear first so a fault raised in the same cycle overrides it.
            if (flag_clr) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (cmd_op)
                            OP_PUSH: begin
                                if (push_out_of_range(esp_in)) begin
                                    overflow <= 1'b1;
                                end else begin
                                    state     <= PUSH_MEM;
                                    cmd_ready <= 1'b0;
                                    mem_req   <= 1'b1;
                                    mem_we    <= 1'b1;
                                    mem_addr  <= push_addr;
                                    mem_wdata <= cmd_data;
                                end
                            end
                            OP_POP: begin
                                if (pop_out_of_range(esp_in)) begin
                                    underflow <= 1'b1;
                                end else begin
                                    state     <= POP_MEM;
                                    cmd_ready <= 1'b0;
                                    mem_req   <= 1'b1;
                                    mem_we    <= 1'b0;
                                    mem_addr  <= esp_in;
                                end
                            end
                            OP_LOAD: begin
                                state     <= ESP_WR;
                                cmd_ready <= 1'b0;
                                esp_rw    <= ESP_WRITE;
                                esp_wdata <= cmd_data;
                            end
                            default: ;
                        endcase
                    end
                end
                // The pushed address is exactly the new ESP value.
                PUSH_MEM: begin
                    if (mem_ready) begin
                        state     <= ESP_WR;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        esp_rw    <= ESP_WRITE;
                        esp_wdata <= mem_addr;
                    end
                end
                POP_MEM: begin
                    if (mem_ready) begin
                        state     <= ESP_WR;
                        mem_req   <= 1'b0;
                        esp_rw    <= ESP_WRITE;
                        esp_wdata <= mem_addr + 32'd4;
                        pop_valid <= 1'b1;
                        pop_data  <= mem_rdata;
                    end
                end
                ESP_WR: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    esp_rw    <= ESP_HOLD;
                    pop_valid <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    esp_rw    <= ESP_HOLD;
                    mem_req   <= 1'b0;
                    pop_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: spec vector table, hand-written flag/reset sequences and
// randomized commands checked against a transaction-level stack model.
module tb_stack_ctrl;

    localparam logic [31:0] TOP   = 32'h000fffff;
    localparam logic [31:0] LIMIT = 32'h000f0000;

    logic        clock_5 = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_data;
    logic        cmd_ready;
    logic [31:0] esp_in;
    logic [3:0]  esp_rw;
    logic [31:0] esp_wdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready;
    logic        pop_valid;
    logic [31:0] pop_data;
    logic        overflow, underflow, flag_clr;

    int total = 0;
    int bad   = 0;

    stack_ctrl #(.STACK_TOP(TOP), .STACK_LIMIT(LIMIT)) dut (
        .clock_5(clock_5), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cmd_ready(cmd_ready), .esp_in(esp_in), .esp_rw(esp_rw),
        .esp_wdata(esp_wdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pop_valid(pop_valid), .pop_data(pop_data), .overflow(overflow),
        .underflow(underflow), .flag_clr(flag_clr)
    );

    always #5 clock_5 = ~clock_5;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          lat;
        int          mem_cyc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          unstable;
        int          wr_cnt;
        logic [31:0] esp_w;
        int          pop_cnt;
        logic [31:0] pop_d;
        bit          badrw;
    } obs_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] data, esp, rdata;
        int          dly;
        int          lat, mem;
        logic [31:0] addr;
        int          wr;
        logic [31:0] espw;
        int          pop;
        logic [31:0] popd;
        logic        ovf, unf;
    } vec_t;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    // Issue one command at a negedge with cmd_ready=1 and observe it until the controller is idle again.
    task automatic do_cmd(input logic [1:0] op, input logic [31:0] data, input logic [31:0] esp,
                          input logic [31:0] rdata, input int dly, input logic clr, output obs_t o);
        int memcnt;
        o = '{default: 0};
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data; esp_in = esp;
        mem_rdata = rdata; flag_clr = clr; mem_ready = 1'($urandom_range(0, 1));
        @(posedge clock_5); @(negedge clock_5);
        cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_data = $urandom; esp_in = $urandom;
        flag_clr = 1'b0;
        o.lat = 1; memcnt = 0;
        while (!cmd_ready && o.lat < 60) begin
            o.lat++;
            if (mem_req) begin
                if (memcnt == 0) begin
                    o.we = mem_we; o.addr = mem_addr; o.wdata = mem_wdata;
                end else if (mem_we !== o.we || mem_addr !== o.addr || mem_wdata !== o.wdata) begin
                    o.unstable = 1;
                end
                o.mem_cyc++;
                mem_ready = (memcnt >= dly);
                memcnt++;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            if (esp_rw == 4'h2) begin
                o.wr_cnt++; o.esp_w = esp_wdata;
            end else if (esp_rw !== 4'h0) begin
                o.badrw = 1;
            end
            if (pop_valid) begin
                o.pop_cnt++; o.pop_d = pop_data;
                if (esp_rw != 4'h2) o.badrw = 1;
            end
            @(posedge clock_5); @(negedge clock_5);
        end
    endtask

    task automatic clear_flags();
        flag_clr = 1'b1;
        @(posedge clock_5); @(negedge clock_5);
        flag_clr = 1'b0;
    endtask

    task automatic cmp(input string p, input obs_t o, input obs_t e, input logic eo, input logic eu);
        chk({p, ".latency"}, o.lat, e.lat);
        chk({p, ".mem_cycles"}, o.mem_cyc, e.mem_cyc);
        if (e.mem_cyc > 0) begin
            chk({p, ".mem_we"}, o.we, e.we);
            chk({p, ".mem_addr"}, o.addr, e.addr);
            if (e.we) chk({p, ".mem_wdata"}, o.wdata, e.wdata);
            chk({p, ".req_stable"}, o.unstable, 0);
        end
        chk({p, ".esp_writes"}, o.wr_cnt, e.wr_cnt);
        if (e.wr_cnt > 0) chk({p, ".esp_wdata"}, o.esp_w, e.esp_w);
        chk({p, ".pop_pulses"}, o.pop_cnt, e.pop_cnt);
        if (e.pop_cnt > 0) chk({p, ".pop_data"}, o.pop_d, e.pop_d);
        chk({p, ".esp_rw_pop_legal"}, o.badrw, 0);
        chk({p, ".overflow"}, overflow, eo);
        chk({p, ".underflow"}, underflow, eu);
    endtask

    // Reference stack model: what a command should do, from the stack rules alone.
    function automatic obs_t model(input logic [1:0] op, input logic [31:0] data, input logic [31:0] esp,
                                   input logic [31:0] rdata, input int dly, output bit fo, output bit fu);
        obs_t e;
        logic [31:0] below;
        e = '{default: 0};
        fo = 0; fu = 0; e.lat = 1;
        below = esp - 32'd4;
        case (op)
            2'b00: if (esp < 32'd4 || below < LIMIT) fo = 1;
                   else begin
                       e.lat = 3 + dly; e.mem_cyc = dly + 1; e.we = 1; e.addr = below;
                       e.wdata = data; e.wr_cnt = 1; e.esp_w = below;
                   end
            2'b01: if (esp >= TOP) fu = 1;
                   else begin
                       e.lat = 3 + dly; e.mem_cyc = dly + 1; e.we = 0; e.addr = esp;
                       e.wr_cnt = 1; e.esp_w = esp + 32'd4; e.pop_cnt = 1; e.pop_d = rdata;
                   end
            2'b10: begin e.lat = 2; e.wr_cnt = 1; e.esp_w = data; end
            default: ;
        endcase
        return e;
    endfunction

    vec_t vecs[12];

    initial begin
        obs_t o, e;
        bit fo, fu;
        logic m_ovf, m_unf;
        logic [31:0] last_pop;

        vecs[0]  = '{2'b00, 32'hdeadbeef, 32'h000fffff, 32'h0, 0, 3, 1, 32'h000ffffb, 1, 32'h000ffffb, 0, 32'h0, 1'b0, 1'b0};
        vecs[1]  = '{2'b01, 32'h0, 32'h000ffffb, 32'hdeadbeef, 3, 6, 4, 32'h000ffffb, 1, 32'h000fffff, 1, 32'hdeadbeef, 1'b0, 1'b0};
        vecs[2]  = '{2'b01, 32'h0, 32'h000fffff, 32'h12345678, 0, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1'b0, 1'b1};
        vecs[3]  = '{2'b00, 32'ha5a5a5a5, 32'h000f0002, 32'h0, 0, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1'b1, 1'b0};
        vecs[4]  = '{2'b10, 32'h00012340, 32'h000fffff, 32'h0, 0, 2, 0, 32'h0, 1, 32'h00012340, 0, 32'h0, 1'b0, 1'b0};
        vecs[5]  = '{2'b11, 32'hffffffff, 32'h000f1000, 32'h0, 0, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1'b0, 1'b0};
        vecs[6]  = '{2'b00, 32'h11112222, 32'h000f0004, 32'h0, 1, 4, 2, 32'h000f0000, 1, 32'h000f0000, 0, 32'h0, 1'b0, 1'b0};
        vecs[7]  = '{2'b00, 32'h00000001, 32'h00000003, 32'h0, 0, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1'b1, 1'b0};
        vecs[8]  = '{2'b01, 32'h0, 32'h00000000, 32'hcafef00d, 0, 3, 1, 32'h0, 1, 32'h00000004, 1, 32'hcafef00d, 1'b0, 1'b0};
        vecs[9]  = '{2'b01, 32'h0, 32'h000ffffe, 32'h00005a5a, 2, 5, 3, 32'h000ffffe, 1, 32'h00100002, 1, 32'h00005a5a, 1'b0, 1'b0};
        vecs[10] = '{2'b00, 32'h00000007, 32'h00000000, 32'h0, 0, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1'b1, 1'b0};
        vecs[11] = '{2'b10, 32'hffffffff, 32'h00000000, 32'h0, 0, 2, 0, 32'h0, 1, 32'hffffffff, 0, 32'h0, 1'b0, 1'b0};

        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b11; cmd_data = 32'h0; esp_in = 32'h0;
        mem_rdata = 32'h0; mem_ready = 1'b0; flag_clr = 1'b0;
        repeat (3) @(posedge clock_5);
        @(negedge clock_5);
        reset = 1'b0;
        @(negedge clock_5);
        chk("reset.cmd_ready", cmd_ready, 1);
        chk("reset.esp_rw", esp_rw, 0);
        chk("reset.esp_wdata", esp_wdata, 0);
        chk("reset.mem_req", mem_req, 0);
        chk("reset.mem_we", mem_we, 0);
        chk("reset.mem_addr", mem_addr, 0);
        chk("reset.mem_wdata", mem_wdata, 0);
        chk("reset.pop_valid", pop_valid, 0);
        chk("reset.pop_data", pop_data, 0);
        chk("reset.overflow", overflow, 0);
        chk("reset.underflow", underflow, 0);

        for (int i = 0; i < 12; i++) begin
            clear_flags();
            do_cmd(vecs[i].op, vecs[i].data, vecs[i].esp, vecs[i].rdata, vecs[i].dly, 1'b0, o);
            e = '{default: 0};
            e.lat = vecs[i].lat; e.mem_cyc = vecs[i].mem; e.we = (vecs[i].op == 2'b00);
            e.addr = vecs[i].addr; e.wdata = vecs[i].data; e.wr_cnt = vecs[i].wr;
            e.esp_w = vecs[i].espw; e.pop_cnt = vecs[i].pop; e.pop_d = vecs[i].popd;
            cmp($sformatf("vec%0d", i), o, e, vecs[i].ovf, vecs[i].unf);
        end

        // Sticky fault does not block the next command; clear drops it.
        clear_flags();
        do_cmd(2'b00, 32'h1, 32'h000f0002, 32'h0, 0, 1'b0, o);
        chk("sticky.set", overflow, 1);
        do_cmd(2'b10, 32'h000055aa, 32'h0, 32'h0, 0, 1'b0, o);
        chk("sticky.load_latency", o.lat, 2);
        chk("sticky.load_wdata", o.esp_w, 32'h000055aa);
        chk("sticky.held", overflow, 1);
        // Fault in the same cycle as flag_clr wins; the other flag is cleared.
        do_cmd(2'b01, 32'h0, 32'h000fffff, 32'h0, 0, 1'b1, o);
        chk("clrwin.underflow", underflow, 1);
        chk("clrwin.overflow_cleared", overflow, 0);
        do_cmd(2'b00, 32'h0, 32'h00000001, 32'h0, 0, 1'b1, o);
        chk("clrwin.overflow", overflow, 1);
        chk("clrwin.underflow_cleared", underflow, 0);
        clear_flags();
        chk("clr.overflow", overflow, 0);

        // Reset in the middle of PUSH_MEM with memory stalled.
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 32'h13579bdf; esp_in = 32'h000fffff; mem_ready = 1'b0;
        @(posedge clock_5); @(negedge clock_5);
        cmd_valid = 1'b0;
        chk("rstmid.mem_req_before", mem_req, 1);
        #2 reset = 1'b1;
        #1;
        chk("rstmid.mem_req_async", mem_req, 0);
        chk("rstmid.mem_we", mem_we, 0);
        chk("rstmid.mem_addr", mem_addr, 0);
        chk("rstmid.mem_wdata", mem_wdata, 0);
        chk("rstmid.esp_rw", esp_rw, 0);
        chk("rstmid.esp_wdata", esp_wdata, 0);
        chk("rstmid.cmd_ready", cmd_ready, 1);
        chk("rstmid.pop_data", pop_data, 0);
        @(posedge clock_5); @(negedge clock_5);
        reset = 1'b0;
        @(negedge clock_5);
        chk("rstmid.no_esp_write", esp_rw, 0);
        chk("rstmid.idle", cmd_ready, 1);

        m_ovf = 0; m_unf = 0; last_pop = 32'h0;
        for (int i = 0; i < 250; i++) begin
            logic [1:0]  op;
            logic [31:0] esp, data, rdata;
            int          dly;
            logic        clr;
            op = 2'($urandom); data = $urandom; rdata = $urandom;
            dly = $urandom_range(0, 3); clr = ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 5))
                0: esp = $urandom;
                1: esp = TOP - 32'($urandom_range(0, 8)) + 32'd2;
                2: esp = LIMIT + 32'($urandom_range(0, 8));
                3: esp = 32'($urandom_range(0, 7));
                4: esp = $urandom_range(32'h000f0000, 32'h000ffffe);
                default: esp = LIMIT - 32'($urandom_range(0, 3));
            endcase
            e = model(op, data, esp, rdata, dly, fo, fu);
            m_ovf = fo ? 1'b1 : (clr ? 1'b0 : m_ovf);
            m_unf = fu ? 1'b1 : (clr ? 1'b0 : m_unf);
            if (e.pop_cnt > 0) last_pop = rdata;
            do_cmd(op, data, esp, rdata, dly, clr, o);
            cmp($sformatf("rnd%0d", i), o, e, m_ovf, m_unf);
            chk($sformatf("rnd%0d.pop_hold", i), pop_data, last_pop);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 SHALL provide parameter STACK_TOP, default 32'h000fffff, the empty-stack ESP value.
REQ-002 SHALL provide parameter STACK_LIMIT, default 32'h000f0000, the lowest legal push address.
REQ-003 SHALL provide port clock_5  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port cmd_valid  input  1  command request.
REQ-006 SHALL provide port cmd_op  input  2  command: 2'b00 PUSH, 2'b01 POP, 2'b10 LOAD_ESP, 2'b11 NOP.
REQ-007 SHALL provide port cmd_data  input  32  push data or new ESP value.
REQ-008 SHALL provide port cmd_ready  output  1  controller idle and able to accept.
REQ-009 SHALL provide port esp_in  input  32  current ESP from the ESP register.
REQ-010 SHALL provide port esp_rw  output  4  ESP register control: 4'h2 write, 4'h0 hold.
REQ-011 SHALL provide port esp_wdata  output  32  ESP write value.
REQ-012 SHALL provide ports mem_req (out 1), mem_we (out 1), mem_addr (out 32), mem_wdata (out 32), mem_rdata (in 32), mem_ready (in 1): the stack memory handshake.
REQ-013 SHALL provide ports pop_valid (out 1) and pop_data (out 32): the popped word.
REQ-014 SHALL provide ports overflow (out 1), underflow (out 1) and flag_clr (in 1): sticky fault flags and their clear.

Function
REQ-015 States SHALL be IDLE, PUSH_MEM, POP_MEM, ESP_WR.
REQ-016 cmd_ready SHALL be 1 only in IDLE; a command is accepted when cmd_valid && cmd_ready at a clock edge.
REQ-017 On an accepted command, cmd_op and cmd_data SHALL be registered; later changes on the inputs SHALL have no effect.
REQ-018 PUSH: new = esp_in - 32'd4 (modulo 2^32); if new < STACK_LIMIT or esp_in < 32'd4, SHALL set overflow, stay in IDLE and make no memory or ESP access; otherwise SHALL go to PUSH_MEM.
REQ-019 PUSH_MEM SHALL drive mem_req=1, mem_we=1, mem_addr=new, mem_wdata=data; all SHALL be held stable until the cycle in which mem_ready=1, then SHALL go to ESP_WR with esp_wdata=new.
REQ-020 POP: if esp_in >= STACK_TOP, SHALL set underflow, stay in IDLE and make no access; otherwise SHALL go to POP_MEM.
REQ-021 POP_MEM SHALL drive mem_req=1, mem_we=0, mem_addr=esp_in as captured at acceptance, until mem_ready=1; mem_rdata SHALL be captured in that cycle, then SHALL go to ESP_WR with esp_wdata=captured ESP + 32'd4.
REQ-022 LOAD_ESP SHALL go directly to ESP_WR with esp_wdata=cmd_data; there SHALL be no range check.
REQ-023 NOP SHALL be accepted and SHALL have no effect.
REQ-024 ESP_WR SHALL last exactly one cycle with esp_rw=4'h2, then SHALL return to IDLE; in every other state esp_rw SHALL be 4'h0.
REQ-025 For POP, pop_valid SHALL pulse for exactly the ESP_WR cycle with pop_data=captured word; pop_data SHALL hold its value afterwards.
REQ-026 mem_req SHALL be 0 outside PUSH_MEM/POP_MEM; mem_ready SHALL be ignored while mem_req=0.
REQ-027 Latency, accept to return to IDLE (mem_ready in the first memory cycle): PUSH/POP 3 cycles; LOAD_ESP 2 cycles; faulted or NOP 1 cycle.
REQ-028 overflow/underflow SHALL be sticky; flag_clr=1 SHALL clear both; a fault setting in the same cycle as flag_clr SHALL win (flag reads 1).
REQ-029 A fault SHALL NOT block later commands.

Reset
REQ-030 reset=1 SHALL immediately force state IDLE, cmd_ready=1, esp_rw=4'h0, esp_wdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, pop_valid=0, pop_data=0, overflow=0, underflow=0.
REQ-031 Reset asserted mid-transaction SHALL abandon the transaction without an ESP write; mem_req SHALL drop asynchronously.

Verification
REQ-032 esp_in=32'h000fffff, PUSH 32'hdeadbeef, mem_ready=1 -> mem write addr 32'h000ffffb, data 32'hdeadbeef; next cycle esp_rw=4'h2, esp_wdata=32'h000ffffb.
REQ-033 esp_in=32'h000ffffb, POP, mem_rdata=32'hdeadbeef, mem_ready delayed 3 cycles -> request held stable for 4 cycles; then pop_valid=1, pop_data=32'hdeadbeef, esp_wdata=32'h000fffff.
REQ-034 esp_in=32'h000fffff, POP -> underflow=1, mem_req never 1, esp_rw stays 4'h0, cmd_ready=1 next cycle.
REQ-035 esp_in=32'h000f0002, PUSH -> overflow=1, no access; then flag_clr=1 -> overflow=0.
REQ-036 LOAD_ESP 32'h00012340 -> one cycle with esp_rw=4'h2, esp_wdata=32'h00012340, then IDLE.
REQ-037 Reset asserted during PUSH_MEM with mem_ready=0 -> mem_req=0 without waiting for a clock edge, no ESP write, all outputs at reset values.
